// File: rtl/bg_fill_sequencer.sv
// Per-line background fill scheduler: walks one line of pixels, classifies each into
// sky/grass/ground and fetches bit-packed grass indices from the pattern ROM.
module bg_fill_sequencer #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int SKY_END   = 300,
   parameter int GRASS_END = 400,
   parameter int GRASS_W   = 52,
   parameter int GRASS_BPP = 3,
   parameter int ADDR_W    = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              line_start,
   input  logic [9:0]        line_y,
   output logic              rom_req,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic              rom_ack,
   input  logic [2:0]        rom_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [9:0]        pix_x,
   output logic [9:0]        pix_y,
   output logic [1:0]        region,
   output logic [2:0]        grass_idx,
   output logic              busy,
   output logic              line_done,
   output logic              overrun
);
   // state | meaning
   // IDLE  | waiting for line_start
   // LOAD  | derive region and grass row base for the latched line
   // FETCH | grass ROM read outstanding for the current pixel
   // EMIT  | pixel beat offered downstream
   // DONE  | last pixel accepted, line_done pulse
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_EMIT, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] ROW_BITS = ADDR_W'(GRASS_W * GRASS_BPP);
   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'((GRASS_W - 1) * GRASS_BPP);
   localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(GRASS_BPP);
   localparam logic [9:0]        Y_LIMIT  = 10'(V_ACTIVE);
   localparam logic [9:0]        Y_SKY    = 10'(SKY_END);
   localparam logic [9:0]        Y_GRASS  = 10'(GRASS_END);
   localparam logic [9:0]        X_LAST   = 10'(H_ACTIVE - 1);

   state_t              state_q, state_d;
   logic [9:0]          x_q, x_d, y_q, y_d;
   logic [1:0]          region_q, region_d;
   logic [ADDR_W-1:0]   rowbase_q, rowbase_d, col_off_q, col_off_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [2:0]          grass_idx_q, grass_idx_d;
   logic                rom_req_q, rom_req_d, pix_valid_q, pix_valid_d;
   logic                busy_q, busy_d, line_done_q, line_done_d, overrun_q, overrun_d;
   logic [ADDR_W-1:0]   dy, rowbase_c, col_next;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      region_d    = region_q;
      rowbase_d   = rowbase_q;
      col_off_d   = col_off_q;
      rom_addr_d  = rom_addr_q;
      grass_idx_d = grass_idx_q;
      rom_req_d   = rom_req_q;
      pix_valid_d = pix_valid_q;
      busy_d      = busy_q;
      line_done_d = 1'b0;
      overrun_d   = overrun_q;

      // Only meaningful inside the grass band; wraps harmlessly elsewhere.
      dy        = ADDR_W'(y_q) - ADDR_W'(Y_SKY);
      rowbase_c = dy * ROW_BITS;
      col_next  = (col_off_q == COL_LAST) ? '0 : col_off_q + COL_STEP;

      if (line_start && state_q != S_IDLE) overrun_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (line_start) begin
               if (line_y < Y_LIMIT) begin
                  y_d     = line_y;
                  x_d     = '0;
                  busy_d  = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            grass_idx_d = '0;
            rowbase_d   = rowbase_c;
            col_off_d   = COL_LAST;
            if (y_q < Y_SKY)        region_d = 2'd0;
            else if (y_q < Y_GRASS) region_d = 2'd1;
            else                    region_d = 2'd2;
            if (y_q >= Y_SKY && y_q < Y_GRASS) begin
               rom_req_d  = 1'b1;
               rom_addr_d = rowbase_c + COL_LAST;
               state_d    = S_FETCH;
            end else begin
               pix_valid_d = 1'b1;
               state_d     = S_EMIT;
            end
         end
         S_FETCH: begin
            if (rom_ack) begin
               grass_idx_d = rom_data;
               rom_req_d   = 1'b0;
               pix_valid_d = 1'b1;
               state_d     = S_EMIT;
            end
         end
         S_EMIT: begin
            if (pix_ready) begin
               if (x_q == X_LAST) begin
                  pix_valid_d = 1'b0;
                  line_done_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  x_d       = x_q + 10'd1;
                  col_off_d = col_next;
                  if (region_q == 2'd1) begin
                     pix_valid_d = 1'b0;
                     rom_req_d   = 1'b1;
                     rom_addr_d  = rowbase_q + col_next;
                     state_d     = S_FETCH;
                  end
               end
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         region_q    <= '0;
         rowbase_q   <= '0;
         col_off_q   <= '0;
         rom_addr_q  <= '0;
         grass_idx_q <= '0;
         rom_req_q   <= 1'b0;
         pix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         line_done_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         region_q    <= region_d;
         rowbase_q   <= rowbase_d;
         col_off_q   <= col_off_d;
         rom_addr_q  <= rom_addr_d;
         grass_idx_q <= grass_idx_d;
         rom_req_q   <= rom_req_d;
         pix_valid_q <= pix_valid_d;
         busy_q      <= busy_d;
         line_done_q <= line_done_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rom_req   = rom_req_q;
   assign rom_addr  = rom_addr_q;
   assign pix_valid = pix_valid_q;
   assign pix_x     = x_q;
   assign pix_y     = y_q;
   assign region    = region_q;
   assign grass_idx = grass_idx_q;
   assign busy      = busy_q;
   assign line_done = line_done_q;
   assign overrun   = overrun_q;

endmodule
